// File: rtl/cheri_trvk_mc_stage.sv
// Multi-channel temporal-revocation check: per-channel query FIFOs arbitrated round-robin
// onto one TSMAP bitmap SRAM port, returning a per-channel clear-tag verdict.
module cheri_trvk_mc_stage #(
   parameter int unsigned NumCh        = 2,
   parameter int unsigned FifoDepth    = 2,
   parameter int unsigned TagW         = 5,
   parameter logic [31:0] HeapBase     = 32'h8000_0000,
   parameter int unsigned TSMapSize    = 1024,
   parameter int unsigned GranuleShift = 3,
   parameter int unsigned AddrW        = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NumCh-1:0]       ch_valid_i,
   output logic [NumCh-1:0]       ch_ready_o,
   input  logic [NumCh*32-1:0]    ch_base_i,
   input  logic [NumCh-1:0]       ch_tag_valid_i,
   input  logic [NumCh-1:0]       ch_err_i,
   input  logic [NumCh-1:0]       ch_seal_i,
   input  logic [NumCh*TagW-1:0]  ch_qtag_i,
   output logic [NumCh-1:0]       res_valid_o,
   output logic                   res_clrtag_o,
   output logic [TagW-1:0]        res_qtag_o,
   output logic                   tsmap_req_o,
   input  logic                   tsmap_gnt_i,
   output logic [AddrW-1:0]       tsmap_addr_o,
   input  logic                   tsmap_rvalid_i,
   input  logic [31:0]            tsmap_rdata_i
);

   localparam int unsigned ChW  = (NumCh > 1) ? $clog2(NumCh) : 1;
   localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int unsigned CntW = PtrW + 1;

   typedef struct packed {
      logic [31:0]     base;
      logic            tag_valid;
      logic            err;
      logic            seal;
      logic [TagW-1:0] qtag;
   } entry_t;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

   state_e           state_q, state_d;
   logic [NumCh-1:0] push_c, pop_c, nonempty_c;
   entry_t           head_c [NumCh];

   // Per-channel FIFO; ready is registered from the post-update occupancy.
   for (genvar g = 0; g < NumCh; g++) begin : g_fifo
      entry_t          mem_q [FifoDepth];
      entry_t          in_c;
      logic [PtrW-1:0] wptr_q, rptr_q;
      logic [CntW-1:0] cnt_q, cnt_d;
      logic            rdy_q;

      assign in_c.base      = ch_base_i[g*32 +: 32];
      assign in_c.tag_valid = ch_tag_valid_i[g];
      assign in_c.err       = ch_err_i[g];
      assign in_c.seal      = ch_seal_i[g];
      assign in_c.qtag      = ch_qtag_i[g*TagW +: TagW];

      assign push_c[g]     = ch_valid_i[g] & rdy_q;
      assign nonempty_c[g] = (cnt_q != '0);
      assign head_c[g]     = mem_q[rptr_q];
      assign ch_ready_o[g] = rdy_q;

      always_comb begin
         cnt_d = cnt_q;
         if (push_c[g] && !pop_c[g]) begin
            cnt_d = cnt_q + CntW'(1);
         end else if (!push_c[g] && pop_c[g]) begin
            cnt_d = cnt_q - CntW'(1);
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            rdy_q  <= 1'b0;
         end else begin
            if (push_c[g]) wptr_q <= wptr_q + PtrW'(1);
            if (pop_c[g])  rptr_q <= rptr_q + PtrW'(1);
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d != CntW'(FifoDepth));
         end
      end

      always_ff @(posedge clk_i) begin
         if (push_c[g]) mem_q[wptr_q] <= in_c;
      end
   end

   // Round-robin pick: first non-empty channel above the last one served.
   logic [ChW-1:0] rr_q, rr_d, sel_c;
   logic           found_c;

   always_comb begin
      sel_c   = rr_q;
      found_c = 1'b0;
      for (int unsigned i = 1; i <= NumCh; i++) begin
         if (!found_c && nonempty_c[ChW'((32'(rr_q) + i) % NumCh)]) begin
            found_c = 1'b1;
            sel_c   = ChW'((32'(rr_q) + i) % NumCh);
         end
      end
   end

   entry_t      sel_e_c;
   logic [31:0] off_c, ptr_c;
   logic [26:0] word_c;
   logic [4:0]  bit_c;
   logic        need_c;

   assign sel_e_c = head_c[sel_c];
   assign off_c   = sel_e_c.base - HeapBase;
   assign ptr_c   = off_c >> GranuleShift;
   assign word_c  = ptr_c[31:5];
   assign bit_c   = ptr_c[4:0];
   assign need_c  = sel_e_c.tag_valid & ~sel_e_c.err & ~sel_e_c.seal &
                    (sel_e_c.base >= HeapBase) & ({5'd0, word_c} < TSMapSize);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= StIdle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (found_c) state_d = need_c ? StReq : StResp;
         StReq:   if (tsmap_gnt_i) state_d = tsmap_rvalid_i ? StResp : StWait;
         StWait:  if (tsmap_rvalid_i) state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   logic [TagW-1:0]  qtag_q, qtag_d;
   logic [ChW-1:0]   ch_q, ch_d;
   logic [4:0]       bit_q, bit_d;
   logic             clrtag_q, clrtag_d;
   logic             req_q, req_d;
   logic [AddrW-1:0] addr_q, addr_d;
   logic [NumCh-1:0] res_valid_q, res_valid_d;
   logic             res_clrtag_q, res_clrtag_d;
   logic [TagW-1:0]  res_qtag_q, res_qtag_d;
   logic             take_c, cap_c;

   // Pop/latch on arbitration, capture bitmap bit on rvalid, stage registered outputs.
   always_comb begin
      pop_c        = '0;
      take_c       = (state_q == StIdle) && found_c;
      cap_c        = tsmap_rvalid_i &&
                     (((state_q == StReq) && tsmap_gnt_i) || (state_q == StWait));
      rr_d         = rr_q;
      qtag_d       = qtag_q;
      ch_d         = ch_q;
      bit_d        = bit_q;
      addr_d       = addr_q;
      clrtag_d     = clrtag_q;
      res_valid_d  = '0;
      res_clrtag_d = 1'b0;
      res_qtag_d   = '0;
      req_d        = (state_d == StReq);
      if (take_c) begin
         pop_c[sel_c] = 1'b1;
         rr_d         = sel_c;
         qtag_d       = sel_e_c.qtag;
         ch_d         = sel_c;
         bit_d        = bit_c;
         addr_d       = AddrW'(word_c);
         clrtag_d     = 1'b0;
      end else if (cap_c) begin
         clrtag_d = tsmap_rdata_i[bit_q];
      end
      if (state_q == StResp) begin
         res_valid_d[ch_q] = 1'b1;
         res_clrtag_d      = clrtag_q;
         res_qtag_d        = qtag_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q         <= ChW'(NumCh - 1);
         qtag_q       <= '0;
         ch_q         <= '0;
         bit_q        <= '0;
         clrtag_q     <= 1'b0;
         req_q        <= 1'b0;
         addr_q       <= '0;
         res_valid_q  <= '0;
         res_clrtag_q <= 1'b0;
         res_qtag_q   <= '0;
      end else begin
         rr_q         <= rr_d;
         qtag_q       <= qtag_d;
         ch_q         <= ch_d;
         bit_q        <= bit_d;
         clrtag_q     <= clrtag_d;
         req_q        <= req_d;
         addr_q       <= addr_d;
         res_valid_q  <= res_valid_d;
         res_clrtag_q <= res_clrtag_d;
         res_qtag_q   <= res_qtag_d;
      end
   end

   assign tsmap_req_o  = req_q;
   assign tsmap_addr_o = addr_q;
   assign res_valid_o  = res_valid_q;
   assign res_clrtag_o = res_clrtag_q;
   assign res_qtag_o   = res_qtag_q;

endmodule

// File: tb/tb_cheri_trvk_mc_stage.sv
// Scoreboard bench for cheri_trvk_mc_stage: directed edge cases plus randomized
// traffic against a bitmap reference model and a variable-latency TSMAP responder.
module tb_cheri_trvk_mc_stage;

   localparam int          NUM_CH = 2;
   localparam int          TAG_W  = 5;
   localparam logic [31:0] HEAP   = 32'h8000_0000;
   localparam int          MAPSZ  = 1024;
   localparam int          ADDR_W = 16;

   typedef struct {
      logic        idle;
      logic [31:0] base;
      logic        tv, err, seal;
      logic [4:0]  qtag;
      int          lat;
   } q_t;

   typedef struct {
      logic       clr;
      logic [4:0] qtag;
      int         acc;
      int         lat;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_n = 1'b0;
   logic [NUM_CH-1:0]       ch_valid = '0, ch_tv = '0, ch_err = '0, ch_seal = '0;
   logic [NUM_CH*32-1:0]    ch_base  = '0;
   logic [NUM_CH*TAG_W-1:0] ch_qtag  = '0;
   logic [NUM_CH-1:0]       ch_ready_o, res_valid_o;
   logic                    res_clrtag_o, tsmap_req_o;
   logic [TAG_W-1:0]        res_qtag_o;
   logic [ADDR_W-1:0]       tsmap_addr_o;
   logic                    tsmap_gnt = 1'b0, tsmap_rvalid = 1'b0;
   logic [31:0]             tsmap_rdata = '0;

   cheri_trvk_mc_stage #(
      .NumCh(NUM_CH), .FifoDepth(2), .TagW(TAG_W), .HeapBase(HEAP),
      .TSMapSize(MAPSZ), .GranuleShift(3), .AddrW(ADDR_W)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_n),
      .ch_valid_i(ch_valid), .ch_ready_o(ch_ready_o), .ch_base_i(ch_base),
      .ch_tag_valid_i(ch_tv), .ch_err_i(ch_err), .ch_seal_i(ch_seal), .ch_qtag_i(ch_qtag),
      .res_valid_o(res_valid_o), .res_clrtag_o(res_clrtag_o), .res_qtag_o(res_qtag_o),
      .tsmap_req_o(tsmap_req_o), .tsmap_gnt_i(tsmap_gnt), .tsmap_addr_o(tsmap_addr_o),
      .tsmap_rvalid_i(tsmap_rvalid), .tsmap_rdata_i(tsmap_rdata)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0, n_err = 0, cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model: one bitmap bit per 8-byte granule, 32 granules per word.
   logic [31:0] tsmap_mem [MAPSZ];

   function automatic logic model_look(logic [31:0] b, logic tv, logic er, logic se);
      longint off;
      if (!tv || er || se || b < HEAP) return 1'b0;
      off = longint'(b) - longint'(HEAP);
      return (off / 256) < longint'(MAPSZ);
   endfunction

   function automatic logic model_clr(logic [31:0] b, logic tv, logic er, logic se);
      longint off;
      if (!model_look(b, tv, er, se)) return 1'b0;
      off = longint'(b) - longint'(HEAP);
      return tsmap_mem[int'(off / 256)][int'((off % 256) / 8)];
   endfunction

   function automatic q_t mkq(logic [31:0] b, logic tv, logic er, logic se, logic [4:0] t, int lat);
      q_t q;
      q.idle = 1'b0; q.base = b; q.tv = tv; q.err = er; q.seal = se; q.qtag = t; q.lat = lat;
      return q;
   endfunction

   q_t   stim_q [NUM_CH][$];
   exp_t exp_q  [NUM_CH][$];
   int   svc_log[$];
   logic hold [NUM_CH] = '{default: 1'b0};
   q_t   cur  [NUM_CH];
   int   acc_cnt [NUM_CH] = '{default: 0};
   int   exp_look_total = 0, gnt_cnt = 0;
   q_t   drv_s;
   exp_t drv_e, mon_e;

   // Driver: presents queued queries, holds them until accepted, pushes the expectation.
   always @(negedge clk_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (!hold[c]) begin
            ch_valid[c] = 1'b0;
            if (stim_q[c].size() > 0) begin
               drv_s = stim_q[c].pop_front();
               if (!drv_s.idle) begin
                  cur[c] = drv_s;
                  ch_valid[c] = 1'b1;
                  ch_base[c*32 +: 32] = drv_s.base;
                  ch_tv[c] = drv_s.tv; ch_err[c] = drv_s.err; ch_seal[c] = drv_s.seal;
                  ch_qtag[c*TAG_W +: TAG_W] = drv_s.qtag;
               end
            end
         end
         if (ch_valid[c] && ch_ready_o[c]) begin
            drv_e.clr  = model_clr(cur[c].base, cur[c].tv, cur[c].err, cur[c].seal);
            drv_e.qtag = cur[c].qtag;
            drv_e.acc  = cyc + 1;
            drv_e.lat  = cur[c].lat;
            exp_q[c].push_back(drv_e);
            if (model_look(cur[c].base, cur[c].tv, cur[c].err, cur[c].seal)) exp_look_total++;
            acc_cnt[c]++;
            hold[c] = 1'b0;
         end else begin
            hold[c] = ch_valid[c];
         end
      end
   end

   // Monitor: pops the channel's expectation on every result pulse.
   always @(negedge clk_i) begin
      if (rst_n) begin
         if (res_valid_o == '0) begin
            chk("clrtag_idle", 64'(res_clrtag_o), 64'(0));
         end else begin
            chk("res_onehot", 64'($countones(res_valid_o)), 64'(1));
            for (int c = 0; c < NUM_CH; c++) begin
               if (res_valid_o[c]) begin
                  svc_log.push_back(c);
                  if (exp_q[c].size() == 0) begin
                     n_checks++; n_err++;
                     $display("FAIL unexpected_result ch%0d: got qtag 0x%0h, expected no result", c, res_qtag_o);
                  end else begin
                     mon_e = exp_q[c].pop_front();
                     chk($sformatf("ch%0d_clrtag", c), 64'(res_clrtag_o), 64'(mon_e.clr));
                     chk($sformatf("ch%0d_qtag", c), 64'(res_qtag_o), 64'(mon_e.qtag));
                     if (mon_e.lat != 0) chk($sformatf("ch%0d_latency", c), 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                  end
               end
            end
         end
      end
   end

   // TSMAP responder with configurable or random grant / data latency.
   int   gnt_dly = 0, rv_dly = 0, rd_d, gd_d, last_addr = -1;
   logic same_cyc = 1'b0, rand_mode = 1'b0, sc_d;
   int   resp_a;
   initial begin
      forever begin
         @(negedge clk_i);
         if (rst_n && tsmap_req_o) begin
            resp_a = int'(tsmap_addr_o);
            gd_d = rand_mode ? int'($urandom_range(0, 3)) : gnt_dly;
            rd_d = rand_mode ? int'($urandom_range(0, 3)) : rv_dly;
            sc_d = rand_mode ? ($urandom_range(0, 3) == 0) : same_cyc;
            chk("addr_in_map", 64'(resp_a < MAPSZ), 64'(1));
            for (int i = 0; i < gd_d; i++) begin
               @(negedge clk_i);
               if (rst_n) begin
                  chk("req_held", 64'(tsmap_req_o), 64'(1));
                  chk("addr_stable", 64'(tsmap_addr_o), 64'(resp_a));
               end
            end
            last_addr = resp_a;
            gnt_cnt++;
            tsmap_gnt = 1'b1;
            if (sc_d) begin tsmap_rvalid = 1'b1; tsmap_rdata = tsmap_mem[resp_a]; end
            @(negedge clk_i);
            tsmap_gnt = 1'b0; tsmap_rvalid = 1'b0;
            if (!sc_d) begin
               repeat (rd_d) @(negedge clk_i);
               tsmap_rvalid = 1'b1; tsmap_rdata = tsmap_mem[resp_a];
               @(negedge clk_i);
               tsmap_rvalid = 1'b0;
            end
         end
      end
   end

   task automatic drain();
      int i;
      for (i = 0; i < 3000; i++) begin
         @(negedge clk_i);
         if (stim_q[0].size() == 0 && stim_q[1].size() == 0 && !hold[0] && !hold[1] &&
             exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
      end
      n_checks++;
      if (i >= 3000) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d/%0d results pending, expected 0", exp_q[0].size(), exp_q[1].size());
      end
      repeat (4) @(negedge clk_i);
      chk("req_count", 64'(gnt_cnt), 64'(exp_look_total));
   endtask

   task automatic single(input int c, input q_t q);
      @(posedge clk_i);
      stim_q[c].push_back(q);
      drain();
   endtask

   initial begin
      #400_000;
      $display("FAIL watchdog: got no finish, expected finish by 400us");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < MAPSZ; i++) tsmap_mem[i] = $urandom;
      repeat (3) @(negedge clk_i);
      chk("rst_ready", 64'(ch_ready_o), 64'(0));
      chk("rst_res_valid", 64'(res_valid_o), 64'(0));
      chk("rst_clrtag", 64'(res_clrtag_o), 64'(0));
      chk("rst_qtag", 64'(res_qtag_o), 64'(0));
      chk("rst_req", 64'(tsmap_req_o), 64'(0));
      chk("rst_addr", 64'(tsmap_addr_o), 64'(0));
      rst_n = 1'b1;
      @(negedge clk_i);
      chk("ready_after_rst", 64'(ch_ready_o), 64'(2'b11));

      // Basic lookup, revoked and not revoked
      tsmap_mem[1] = 32'h0000_0002;
      single(0, mkq(32'h8000_0108, 1, 0, 0, 5'h0A, 4));
      chk("addr_basic", 64'(last_addr), 64'(1));
      tsmap_mem[1] = 32'hFFFF_FFFD;
      single(0, mkq(32'h8000_0108, 1, 0, 0, 5'h0B, 4));
      tsmap_mem[1] = 32'hFFFF_FFFF;
      single(0, mkq(32'h8000_0108, 1, 1, 0, 5'h0C, 2));
      single(0, mkq(32'h8000_0108, 1, 0, 1, 5'h0D, 2));
      single(1, mkq(32'h8000_0108, 0, 0, 0, 5'h0E, 2));

      // Range edges
      single(0, mkq(32'h7FFF_FFF8, 1, 0, 0, 5'h10, 2));
      single(1, mkq(HEAP + 32'(MAPSZ * 256), 1, 0, 0, 5'h11, 2));
      tsmap_mem[MAPSZ-1] = 32'h8000_0000;
      single(1, mkq(HEAP + 32'(MAPSZ * 256 - 8), 1, 0, 0, 5'h12, 4));
      chk("addr_last_word", 64'(last_addr), 64'(MAPSZ - 1));

      // Both channels burst with slow grants: backpressure and alternating service
      gnt_dly = 3;
      @(posedge clk_i);
      acc_cnt = '{0, 0};
      svc_log.delete();
      for (int k = 0; k < 3; k++) begin
         stim_q[0].push_back(mkq(HEAP + 32'($urandom_range(0, MAPSZ*256-1)), 1, 0, 0, 5'(k + 1), 0));
         stim_q[1].push_back(mkq(HEAP + 32'($urandom_range(0, MAPSZ*256-1)), 1, 0, 0, 5'(k + 17), 0));
      end
      for (int k = 0; k < 40; k++) begin
         @(posedge clk_i);
         if (acc_cnt[1] >= 2) break;
      end
      @(negedge clk_i);
      chk("ch1_full_ready", 64'(ch_ready_o[1]), 64'(0));
      chk("ch0_ready", 64'(ch_ready_o[0]), 64'(1));
      drain();
      chk("svc_count", 64'(svc_log.size()), 64'(6));
      for (int k = 0; k < 6 && k < svc_log.size(); k++)
         chk($sformatf("svc_order_%0d", k), 64'(svc_log[k]), 64'(k % 2));
      gnt_dly = 0;

      // Grant and data in the same cycle
      same_cyc = 1'b1;
      tsmap_mem[5] = 32'h0000_1000;
      single(1, mkq(HEAP + 32'(5*256 + 12*8), 1, 0, 0, 5'h1A, 3));
      same_cyc = 1'b0;

      // Reset while waiting for data with one more query queued
      rv_dly = 8;
      @(posedge clk_i);
      begin
         int g0;
         g0 = gnt_cnt;
         stim_q[0].push_back(mkq(HEAP + 32'h100, 1, 0, 0, 5'h1C, 0));
         stim_q[0].push_back(mkq(HEAP + 32'h200, 1, 0, 0, 5'h1D, 0));
         for (int k = 0; k < 30; k++) begin
            @(negedge clk_i);
            if (gnt_cnt != g0) break;
         end
         chk("rst_test_granted", 64'(gnt_cnt), 64'(g0 + 1));
      end
      @(negedge clk_i);
      rst_n = 1'b0;
      exp_q[0].delete();
      exp_look_total--;
      @(negedge clk_i);
      chk("midrst_ready", 64'(ch_ready_o), 64'(0));
      chk("midrst_req", 64'(tsmap_req_o), 64'(0));
      @(negedge clk_i);
      rst_n = 1'b1;
      @(negedge clk_i);
      chk("midrst_ready_after", 64'(ch_ready_o), 64'(2'b11));
      for (int k = 0; k < 15; k++) begin
         @(negedge clk_i);
         chk("post_rst_no_result", 64'(res_valid_o), 64'(0));
         chk("post_rst_no_req", 64'(tsmap_req_o), 64'(0));
      end
      rv_dly = 0;
      drain();

      // Randomized traffic on both channels
      rand_mode = 1'b1;
      @(posedge clk_i);
      for (int c = 0; c < NUM_CH; c++) begin
         for (int k = 0; k < 60; k++) begin
            q_t q;
            int r;
            logic [31:0] b;
            r = int'($urandom_range(0, 9));
            if (r == 0)      b = HEAP - 32'($urandom_range(1, 4096));
            else if (r == 1) b = HEAP + 32'(MAPSZ * 256) + 32'($urandom_range(0, 4096));
            else             b = HEAP + 32'($urandom_range(0, MAPSZ * 256 - 1));
            q = mkq(b, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) == 0, 5'($urandom), 0);
            q.idle = ($urandom_range(0, 2) == 0);
            stim_q[c].push_back(q);
         end
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/cheri_trvk_mc_stage.md
Name: cheri_trvk_mc_stage

Overview:
- Multi-channel successor to the single-pipe temporal-revocation check.
- Accepts loaded-capability revocation queries from NumCh requesters (CPU load port, TBRE, further background sweepers), each through its own small FIFO.
- Arbitrates round-robin onto one revocation-bitmap (TSMAP) SRAM port that uses a req/gnt/rvalid handshake with variable latency.
- Returns a per-channel clear-tag verdict. Results stay in order within each channel.

Parameters:
- NumCh, 2, number of requester channels (1..8).
- FifoDepth, 2, entries per channel input FIFO (power of 2, ≥2).
- TagW, 5, width of the opaque per-query tag (e.g. RF address).
- HeapBase, 32'h8000_0000, byte address of granule 0 in the bitmap.
- TSMapSize, 1024, number of 32-bit TSMAP words.
- GranuleShift, 3, log2 of the revocation granule in bytes.
- AddrW, 16, TSMAP word-address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- ch_valid_i  in  NumCh  query valid per channel.
- ch_ready_o  out  NumCh  FIFO not full; a query is accepted when valid & ready.
- ch_base_i  in  NumCh*32  decoded capability base address.
- ch_tag_valid_i  in  NumCh  capability tag bit of the loaded value.
- ch_err_i  in  NumCh  load error on this response.
- ch_seal_i  in  NumCh  capability is a sealing capability (exempt from lookup).
- ch_qtag_i  in  NumCh*TagW  opaque query tag.
- res_valid_o  out  NumCh  one-cycle result pulse per channel.
- res_clrtag_o  out  1  1 = capability revoked, clear its tag.
- res_qtag_o  out  TagW  tag of the completing query.
- tsmap_req_o  out  1  SRAM read request.
- tsmap_gnt_i  in  1  request accepted.
- tsmap_addr_o  out  AddrW  word address.
- tsmap_rvalid_i  in  1  read data valid.
- tsmap_rdata_i  in  32  bitmap word.

Behaviour:
- Reset values: all FIFOs empty; ch_ready_o = all ones one cycle after reset release (0 during reset); res_valid_o = 0; res_clrtag_o = 0; res_qtag_o = 0; tsmap_req_o = 0; tsmap_addr_o = 0; FSM in IDLE; round-robin pointer = NumCh-1, so channel 0 has first priority.
- Enqueue: on valid & ready, write {base, tag_valid, err, seal, qtag} at the clock edge. The entry becomes visible at the FIFO head on the next cycle. Valid while not ready is held by the requester; the block neither drops nor duplicates it.
- Lookup computation, at pop:
  - off = base - HeapBase (32-bit, wrapping).
  - ptr = off >> GranuleShift.
  - word = ptr[31:5]; bit = ptr[4:0].
  - need_lookup = tag_valid & ~err & ~seal & (base ≥ HeapBase) & (word < TSMapSize).
- Arbitration: in IDLE, choose the first non-empty channel searching upward from (rr_ptr+1) mod NumCh. Pop it, set rr_ptr to that channel, and latch qtag, channel, bit, word[AddrW-1:0] and need_lookup.
- FSM:
  - IDLE: if any FIFO is non-empty, pop the selected head. Go to REQ if need_lookup, otherwise to RESP with clrtag = 0.
  - REQ: assert tsmap_req_o with tsmap_addr_o stable. On tsmap_gnt_i go to WAIT. If tsmap_rvalid_i arrives in the same cycle as the grant, capture the data and go straight to RESP.
  - WAIT: on tsmap_rvalid_i, capture clrtag = rdata[bit] and go to RESP.
  - RESP: res_valid_o[ch] = 1 for exactly one cycle, with res_clrtag_o and res_qtag_o valid in that cycle; all other cycles drive res_clrtag_o = 0. Return to IDLE.
- Latency, from the accept edge to res_valid_o:
  - Non-lookup: 2 cycles.
  - Lookup with immediate grant and rvalid one cycle after the grant: 4 cycles.
- Ordering and outstanding: at most one TSMAP request outstanding. Results within a channel appear in acceptance order. Across channels, results appear in service order.
- Boundaries:
  - A full FIFO deasserts ready in the cycle after its last free slot is written.
  - A simultaneous push and pop on a full FIFO is not permitted (ready = 0 blocks the push). A simultaneous push and pop on a non-full FIFO is legal and leaves the count unchanged.
  - word == TSMapSize or base < HeapBase: no request is issued and clrtag = 0.
  - Reset asserted mid-lookup: the FSM returns to IDLE and FIFOs clear. Any late rvalid after reset release is ignored because it is only consumed in REQ/WAIT.

Test Plan:
- NumCh=2: ch0 query base 0x8000_0108, tag_valid=1 → tsmap_addr_o=0x001; bit 1; rdata=0x0000_0002 → res_valid_o=2'b01, clrtag=1, qtag echoed, 4 cycles after accept.
- Same query with rdata=0xFFFF_FFFD → clrtag=0. With err=1, seal=1 or tag_valid=0 → no tsmap_req_o, clrtag=0, 2-cycle latency.
- Range edges:
  - base=0x7FFF_FFF8 → no request, clrtag=0.
  - base=HeapBase+TSMapSize*256 → no request, clrtag=0.
  - base=HeapBase+TSMapSize*256-8 → request with addr=TSMapSize-1, bit 31.
- Both channels push 3 queries in the same cycles, with tsmap_gnt_i delayed 3 cycles on every request → ch1 deasserts ready after its second entry; service order is ch0,ch1,ch0,ch1,ch0,ch1; each channel's qtags stay in order.
- Reset asserted while in WAIT with 1 entry queued → after release: FIFOs empty, no res_valid_o pulse, and a stray tsmap_rvalid_i produces no result.
- tsmap_gnt_i and tsmap_rvalid_i in the same cycle → result captured correctly, res_valid_o 1 cycle later, and exactly one pulse.
